// File: rtl/hwpe_arb_pkg.sv
// hwpe_arb_pkg: shared dimensions, request payload type and index helper for the TCDM port arbiter.
package hwpe_arb_pkg;
  localparam int N_HWPE = 2;
  localparam int MP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CNT_W = 16;
  localparam int IDX_W = (N_HWPE > 1) ? $clog2(N_HWPE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef logic [IDX_W-1:0] idx_t;
  typedef struct packed {
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } tcdm_req_t;
  function automatic idx_t wrap_inc(idx_t i);
    return (int'(i) >= N_HWPE - 1) ? '0 : i + idx_t'(1);
  endfunction
endpackage

// File: rtl/hwpe_rr_arb_port.sv
// hwpe_rr_arb_port: round-robin arbitration of one shared TCDM port with one-deep response steering.
module hwpe_rr_arb_port
  import hwpe_arb_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_HWPE-1:0]      i_elig,
  input  tcdm_req_t [N_HWPE-1:0] i_req,
  input  logic                   i_gnt,
  input  logic                   i_r_valid,
  output logic                   o_req,
  output tcdm_req_t              o_req_pl,
  output logic [N_HWPE-1:0]      o_gnt,
  output logic [N_HWPE-1:0]      o_r_valid,
  output logic                   o_pend,
  output logic                   o_err
);
  idx_t r_ptr, r_pend_idx, w_win, w_c;
  logic r_pend_vld, w_any, w_hs;
  // first eligible requester at or after the pointer, wrapping
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_c = r_ptr;
    for (int k = 0; k < N_HWPE; k++) begin
      if (!w_any && i_elig[w_c]) begin
        w_win = w_c;
        w_any = 1'b1;
      end
      w_c = wrap_inc(w_c);
    end
  end
  assign o_req     = w_any & ~rst_i;
  assign w_hs      = o_req & i_gnt;
  assign o_req_pl  = w_any ? i_req[w_win] : '0;
  assign o_gnt     = w_hs ? N_HWPE'(1) << w_win : '0;
  assign o_r_valid = (i_r_valid & r_pend_vld & ~rst_i) ? N_HWPE'(1) << r_pend_idx : '0;
  assign o_pend    = r_pend_vld;
  assign o_err     = i_r_valid & ~r_pend_vld;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
      r_pend_vld <= 1'b0;
      r_pend_idx <= '0;
    end else begin
      r_pend_vld <= w_hs;
      r_ptr <= w_hs ? wrap_inc(w_win) : r_ptr;
      r_pend_idx <= w_hs ? w_win : r_pend_idx;
    end
  end
endmodule

// File: rtl/hwpe_tcdm_port_arbiter.sv
// hwpe_tcdm_port_arbiter: shares MP TCDM master ports between N_HWPE accelerators,
// with per-requester enables, saturating grant counters and a sticky protocol-error flag.
module hwpe_tcdm_port_arbiter
  import hwpe_arb_pkg::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [N_HWPE-1:0]                     en_i,
  input  logic                                  cnt_clr_i,
  input  logic [N_HWPE-1:0][MP-1:0]             in_req_i,
  input  logic [N_HWPE-1:0][MP-1:0][AW-1:0]     in_add_i,
  input  logic [N_HWPE-1:0][MP-1:0]             in_wen_i,
  input  logic [N_HWPE-1:0][MP-1:0][BW-1:0]     in_be_i,
  input  logic [N_HWPE-1:0][MP-1:0][DW-1:0]     in_wdata_i,
  output logic [N_HWPE-1:0][MP-1:0]             in_gnt_o,
  output logic [N_HWPE-1:0][MP-1:0][DW-1:0]     in_r_rdata_o,
  output logic [N_HWPE-1:0][MP-1:0]             in_r_valid_o,
  output logic [MP-1:0]                         out_req_o,
  output logic [MP-1:0][AW-1:0]                 out_add_o,
  output logic [MP-1:0]                         out_wen_o,
  output logic [MP-1:0][BW-1:0]                 out_be_o,
  output logic [MP-1:0][DW-1:0]                 out_wdata_o,
  input  logic [MP-1:0]                         out_gnt_i,
  input  logic [MP-1:0][DW-1:0]                 out_r_rdata_i,
  input  logic [MP-1:0]                         out_r_valid_i,
  output logic [N_HWPE-1:0][CNT_W-1:0]          grant_cnt_o,
  output logic                                  busy_o,
  output logic                                  err_o
);
  logic [MP-1:0][N_HWPE-1:0] w_elig, w_gnt, w_rvld;
  tcdm_req_t [MP-1:0][N_HWPE-1:0] w_pl;
  tcdm_req_t [MP-1:0] w_opl;
  logic [MP-1:0] w_pend, w_err;
  logic [N_HWPE-1:0][CNT_W:0] w_sum;
  logic [N_HWPE-1:0][CNT_W-1:0] r_cnt;
  logic r_err;
  always_comb begin
    w_elig = '0;
    w_pl = '0;
    for (int p = 0; p < MP; p++)
      for (int h = 0; h < N_HWPE; h++) begin
        w_elig[p][h] = in_req_i[h][p] & en_i[h];
        w_pl[p][h] = {in_add_i[h][p], in_wen_i[h][p], in_be_i[h][p], in_wdata_i[h][p]};
      end
  end
  always_comb begin
    in_gnt_o = '0;
    in_r_valid_o = '0;
    for (int p = 0; p < MP; p++)
      for (int h = 0; h < N_HWPE; h++) begin
        in_gnt_o[h][p] = w_gnt[p][h];
        in_r_valid_o[h][p] = w_rvld[p][h];
      end
  end
  for (genvar p = 0; p < MP; p++) begin : g_port
    hwpe_rr_arb_port u_port (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_elig    (w_elig[p]),
      .i_req     (w_pl[p]),
      .i_gnt     (out_gnt_i[p]),
      .i_r_valid (out_r_valid_i[p]),
      .o_req     (out_req_o[p]),
      .o_req_pl  (w_opl[p]),
      .o_gnt     (w_gnt[p]),
      .o_r_valid (w_rvld[p]),
      .o_pend    (w_pend[p]),
      .o_err     (w_err[p])
    );
    assign out_add_o[p]   = w_opl[p].add;
    assign out_wen_o[p]   = w_opl[p].wen;
    assign out_be_o[p]    = w_opl[p].be;
    assign out_wdata_o[p] = w_opl[p].wdata;
  end
  // read data is broadcast; only the valid is steered to the recorded winner
  assign in_r_rdata_o = {N_HWPE{out_r_rdata_i}};
  always_comb begin
    w_sum = '0;
    for (int h = 0; h < N_HWPE; h++) begin
      w_sum[h] = {1'b0, r_cnt[h]};
      for (int p = 0; p < MP; p++) w_sum[h] = w_sum[h] + (CNT_W+1)'(w_gnt[p][h]);
    end
  end
  always_ff @(posedge clk_i) begin
    for (int h = 0; h < N_HWPE; h++)
      r_cnt[h] <= (rst_i || cnt_clr_i) ? '0 : w_sum[h][CNT_W] ? CNT_MAX : w_sum[h][CNT_W-1:0];
    r_err <= (rst_i || cnt_clr_i) ? 1'b0 : r_err | (|w_err);
  end
  assign grant_cnt_o = r_cnt;
  assign err_o = r_err;
  assign busy_o = (|w_elig) | (|w_pend);
endmodule

// File: tb/tb_hwpe_tcdm_port_arbiter.sv
// tb_hwpe_tcdm_port_arbiter: scenario tasks with a response scoreboard and a small reference model.
module tb_hwpe_tcdm_port_arbiter;
  import hwpe_arb_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i, cnt_clr_i;
  logic [N_HWPE-1:0] en_i;
  logic [N_HWPE-1:0][MP-1:0] in_req_i, in_wen_i, in_gnt_o, in_r_valid_o;
  logic [N_HWPE-1:0][MP-1:0][AW-1:0] in_add_i;
  logic [N_HWPE-1:0][MP-1:0][BW-1:0] in_be_i;
  logic [N_HWPE-1:0][MP-1:0][DW-1:0] in_wdata_i, in_r_rdata_o;
  logic [MP-1:0] out_req_o, out_wen_o, out_gnt_i, out_r_valid_i;
  logic [MP-1:0][AW-1:0] out_add_o;
  logic [MP-1:0][BW-1:0] out_be_o;
  logic [MP-1:0][DW-1:0] out_wdata_o, out_r_rdata_i;
  logic [N_HWPE-1:0][CNT_W-1:0] grant_cnt_o;
  logic busy_o, err_o;

  hwpe_tcdm_port_arbiter u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .cnt_clr_i(cnt_clr_i),
    .in_req_i(in_req_i), .in_add_i(in_add_i), .in_wen_i(in_wen_i), .in_be_i(in_be_i),
    .in_wdata_i(in_wdata_i), .in_gnt_o(in_gnt_o), .in_r_rdata_o(in_r_rdata_o),
    .in_r_valid_o(in_r_valid_o), .out_req_o(out_req_o), .out_add_o(out_add_o),
    .out_wen_o(out_wen_o), .out_be_o(out_be_o), .out_wdata_o(out_wdata_o),
    .out_gnt_i(out_gnt_i), .out_r_rdata_i(out_r_rdata_i), .out_r_valid_i(out_r_valid_i),
    .grant_cnt_o(grant_cnt_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int h; int p; logic [DW-1:0] d;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  int m_ptr[MP], m_pend_h[MP], m_cnt[N_HWPE];
  bit m_pend[MP], m_err, auto_resp;

  function automatic int model_win(int p);
    for (int k = 0; k < N_HWPE; k++) begin
      int h = (m_ptr[p] + k) % N_HWPE;
      if (in_req_i[h][p] && en_i[h]) return h;
    end
    return -1;
  endfunction

  // advance the model over the coming edge, clock once, then drive the responses it expects
  task automatic advance();
    bit hs[MP];
    int w[MP];
    if (rst_i) begin
      for (int p = 0; p < MP; p++) begin m_ptr[p] = 0; m_pend[p] = 0; m_pend_h[p] = 0; end
      for (int h = 0; h < N_HWPE; h++) m_cnt[h] = 0;
      m_err = 0;
    end else begin
      for (int p = 0; p < MP; p++) begin
        if (out_r_valid_i[p] && !m_pend[p]) m_err = 1;
        w[p] = model_win(p);
        hs[p] = (w[p] >= 0) && out_gnt_i[p];
        if (hs[p]) m_cnt[w[p]] = (m_cnt[w[p]] >= int'(CNT_MAX)) ? int'(CNT_MAX) : m_cnt[w[p]] + 1;
      end
      if (cnt_clr_i) begin
        for (int h = 0; h < N_HWPE; h++) m_cnt[h] = 0;
        m_err = 0;
      end
      for (int p = 0; p < MP; p++) begin
        m_pend[p] = hs[p];
        if (hs[p]) begin m_pend_h[p] = w[p]; m_ptr[p] = (w[p] + 1) % N_HWPE; end
      end
    end
    @(posedge clk_i); #1;
    out_r_valid_i = '0;
    for (int p = 0; p < MP; p++)
      if (auto_resp && m_pend[p]) begin
        out_r_valid_i[p] = 1'b1;
        out_r_rdata_i[p] = $urandom;
        sb.push_back('{m_pend_h[p], p, out_r_rdata_i[p]});
      end
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    advance();
    advance();
    rst_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    for (int p = 0; p < MP; p++)
      for (int h = 0; h < N_HWPE; h++)
        if (in_r_valid_o[h][p] === 1'b1) begin
          n_chk++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_resp: unexpected valid at h%0d p%0d, none required", h, p);
          end else begin
            e = sb.pop_front();
            if (e.h != h || e.p != p || in_r_rdata_o[h][p] !== e.d) begin
              n_fail++;
              $display("FAIL sb_resp: got h%0d p%0d d=%h, required h%0d p%0d d=%h", h, p, in_r_rdata_o[h][p], e.h, e.p, e.d);
            end
          end
        end
  end

  task automatic test_reset();
    logic [N_HWPE-1:0][MP-1:0] eg;
    rst_i = 1'b1; in_req_i = '1; en_i = '1; out_gnt_i = '1; out_r_valid_i = '1;
    #1;
    n_chk++; if (out_req_o !== '0) begin n_fail++; $display("FAIL rst_out_req: got %h required 0", out_req_o); end
    n_chk++; if (in_gnt_o !== '0) begin n_fail++; $display("FAIL rst_gnt: got %h required 0", in_gnt_o); end
    n_chk++; if (in_r_valid_o !== '0) begin n_fail++; $display("FAIL rst_rvalid: got %h required 0", in_r_valid_o); end
    out_r_valid_i = '0;
    advance();
    advance();
    n_chk++; if (grant_cnt_o !== '0) begin n_fail++; $display("FAIL rst_cnt: got %h required 0", grant_cnt_o); end
    n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", err_o); end
    rst_i = 1'b0;
    #1;
    eg = '0; eg[0] = '1;
    n_chk++; if (in_gnt_o !== eg) begin n_fail++; $display("FAIL first_winner: got %h required %h", in_gnt_o, eg); end
    for (int p = 0; p < MP; p++) begin
      n_chk++;
      if (out_add_o[p] !== in_add_i[0][p]) begin n_fail++; $display("FAIL first_payload p%0d: got %h required %h", p, out_add_o[p], in_add_i[0][p]); end
    end
    advance();
    in_req_i = '0;
    advance();
  endtask

  task automatic test_fairness();
    reset_dut();
    en_i = '1; out_gnt_i = '1; in_req_i = '0; in_req_i[0][0] = 1'b1; in_req_i[1][0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_chk++;
      if ({in_gnt_o[1][0], in_gnt_o[0][0]} !== ((i % 2) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_alternate cycle %0d: got %b%b required winner h%0d", i, in_gnt_o[1][0], in_gnt_o[0][0], i % 2);
      end
      advance();
    end
    in_req_i = '0;
    advance();
    n_chk++; if (grant_cnt_o[0] !== 16'd4) begin n_fail++; $display("FAIL rr_cnt0: got %0d required 4", grant_cnt_o[0]); end
    n_chk++; if (grant_cnt_o[1] !== 16'd4) begin n_fail++; $display("FAIL rr_cnt1: got %0d required 4", grant_cnt_o[1]); end
  endtask

  task automatic test_response();
    logic [N_HWPE-1:0][MP-1:0] ev;
    auto_resp = 1'b0;
    in_req_i = '0; in_req_i[1][2] = 1'b1; in_add_i[1][2] = 32'h100; in_wen_i[1][2] = 1'b1; out_gnt_i = '1;
    #1;
    n_chk++; if (out_add_o[2] !== 32'h100 || out_wen_o[2] !== 1'b1) begin n_fail++; $display("FAIL resp_req: got add %h wen %b required 100 1", out_add_o[2], out_wen_o[2]); end
    n_chk++; if (in_gnt_o[1][2] !== 1'b1) begin n_fail++; $display("FAIL resp_gnt: got %b required 1", in_gnt_o[1][2]); end
    advance();
    in_req_i = '0;
    out_r_valid_i[2] = 1'b1; out_r_rdata_i[2] = 32'hDEADBEEF;
    sb.push_back('{1, 2, 32'hDEADBEEF});
    #1;
    ev = '0; ev[1][2] = 1'b1;
    n_chk++; if (in_r_valid_o !== ev) begin n_fail++; $display("FAIL resp_route: got %h required %h", in_r_valid_o, ev); end
    n_chk++; if (in_r_rdata_o[1][2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL resp_data: got %h required deadbeef", in_r_rdata_o[1][2]); end
    n_chk++; if (in_r_rdata_o[0][2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL resp_bcast: got %h required deadbeef", in_r_rdata_o[0][2]); end
    advance();
    auto_resp = 1'b1;
  endtask

  task automatic test_stall();
    in_req_i = '0; in_req_i[0][0] = 1'b1; out_gnt_i = '1;
    advance();
    in_req_i[1][0] = 1'b1; out_gnt_i = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (in_gnt_o !== '0) begin n_fail++; $display("FAIL stall_gnt: got %h required 0", in_gnt_o); end
      n_chk++; if (out_req_o[0] !== 1'b1 || out_add_o[0] !== in_add_i[1][0]) begin n_fail++; $display("FAIL stall_hold: got req %b add %h required 1 %h", out_req_o[0], out_add_o[0], in_add_i[1][0]); end
      advance();
    end
    out_gnt_i = '1;
    #1;
    n_chk++; if ({in_gnt_o[1][0], in_gnt_o[0][0]} !== 2'b10) begin n_fail++; $display("FAIL stall_resume: got %b%b required 10", in_gnt_o[1][0], in_gnt_o[0][0]); end
    advance();
    in_req_i = '0;
    advance();
  endtask

  task automatic test_masking();
    logic [N_HWPE-1:0][MP-1:0] eg;
    cnt_clr_i = 1'b1;
    advance();
    cnt_clr_i = 1'b0;
    n_chk++; if (grant_cnt_o !== '0) begin n_fail++; $display("FAIL clr_cnt: got %h required 0", grant_cnt_o); end
    en_i = 2'b01; in_req_i = '1; out_gnt_i = '1;
    eg = '0; eg[0] = '1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_chk++; if (in_gnt_o !== eg) begin n_fail++; $display("FAIL mask_gnt: got %h required %h", in_gnt_o, eg); end
      advance();
    end
    in_req_i = '0;
    advance();
    n_chk++; if (grant_cnt_o[0] !== 16'd24) begin n_fail++; $display("FAIL mask_cnt0: got %0d required 24", grant_cnt_o[0]); end
    n_chk++; if (grant_cnt_o[1] !== 16'd0) begin n_fail++; $display("FAIL mask_cnt1: got %0d required 0", grant_cnt_o[1]); end
    en_i = '1; in_req_i[1][1] = 1'b1;
    #1;
    n_chk++; if (in_gnt_o[1][1] !== 1'b1) begin n_fail++; $display("FAIL mask_pre: got %b required 1", in_gnt_o[1][1]); end
    advance();
    en_i = 2'b01;
    #1;
    n_chk++; if (out_req_o[1] !== 1'b0) begin n_fail++; $display("FAIL mask_drop: got %b required 0", out_req_o[1]); end
    n_chk++; if (in_r_valid_o[1][1] !== 1'b1) begin n_fail++; $display("FAIL mask_pend_resp: got %b required 1", in_r_valid_o[1][1]); end
    advance();
    in_req_i = '0; en_i = '1;
    advance();
  endtask

  task automatic test_back_to_back();
    logic [N_HWPE-1:0] col, ecol;
    logic ebusy;
    int w;
    for (int i = 0; i < 40; i++) begin
      in_req_i = (N_HWPE*MP)'($urandom);
      en_i = N_HWPE'($urandom_range(1, 3));
      out_gnt_i = MP'($urandom);
      #1;
      ebusy = 1'b0;
      for (int p = 0; p < MP; p++) begin
        w = model_win(p);
        ebusy = ebusy | (w >= 0) | m_pend[p];
        ecol = '0;
        for (int h = 0; h < N_HWPE; h++) begin
          col[h] = in_gnt_o[h][p];
          ecol[h] = (w == h) && out_gnt_i[p];
        end
        n_chk++; if (col !== ecol) begin n_fail++; $display("FAIL b2b_gnt c%0d p%0d: got %b required %b", i, p, col, ecol); end
        n_chk++;
        if ({out_add_o[p], out_wdata_o[p]} !== ((w >= 0) ? {in_add_i[w][p], in_wdata_i[w][p]} : '0)) begin
          n_fail++; $display("FAIL b2b_payload c%0d p%0d: got %h %h, winner h%0d", i, p, out_add_o[p], out_wdata_o[p], w);
        end
      end
      n_chk++; if (busy_o !== ebusy) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b required %b", i, busy_o, ebusy); end
      advance();
    end
    in_req_i = '0; en_i = '1;
    advance();
    for (int h = 0; h < N_HWPE; h++) begin
      n_chk++; if (grant_cnt_o[h] !== CNT_W'(m_cnt[h])) begin n_fail++; $display("FAIL b2b_cnt h%0d: got %0d required %0d", h, grant_cnt_o[h], m_cnt[h]); end
    end
  endtask

  task automatic test_err_sat();
    auto_resp = 1'b0;
    in_req_i = '0; out_r_valid_i = '0; out_r_valid_i[3] = 1'b1;
    #1;
    n_chk++; if (in_r_valid_o !== '0) begin n_fail++; $display("FAIL spurious_drop: got %h required 0", in_r_valid_o); end
    n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b required 0", err_o); end
    advance();
    n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b required 1", err_o); end
    advance();
    advance();
    n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b required 1", err_o); end
    cnt_clr_i = 1'b1;
    advance();
    cnt_clr_i = 1'b0;
    n_chk++; if (err_o !== 1'b0 || grant_cnt_o !== '0) begin n_fail++; $display("FAIL clr_err: got err %b cnt %h required 0 0", err_o, grant_cnt_o); end
    in_req_i[0][1] = 1'b1; out_gnt_i = '1;
    advance();
    in_req_i = '0; rst_i = 1'b1; out_r_valid_i[1] = 1'b1;
    #1;
    n_chk++; if (in_r_valid_o !== '0) begin n_fail++; $display("FAIL rst_resp_forced: got %h required 0", in_r_valid_o); end
    advance();
    rst_i = 1'b0; out_r_valid_i[1] = 1'b1;
    advance();
    n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL late_resp_err: got %b required 1", err_o); end
    cnt_clr_i = 1'b1;
    advance();
    cnt_clr_i = 1'b0;
    auto_resp = 1'b1; en_i = 2'b01; in_req_i = '0; in_req_i[0] = '1; out_gnt_i = '1;
    repeat (16383) advance();
    n_chk++; if (grant_cnt_o[0] !== 16'hFFFC) begin n_fail++; $display("FAIL cnt_near: got %h required fffc", grant_cnt_o[0]); end
    advance();
    n_chk++; if (grant_cnt_o[0] !== CNT_MAX) begin n_fail++; $display("FAIL cnt_sat: got %h required ffff", grant_cnt_o[0]); end
    advance();
    n_chk++; if (grant_cnt_o[0] !== CNT_MAX) begin n_fail++; $display("FAIL cnt_hold: got %h required ffff", grant_cnt_o[0]); end
    cnt_clr_i = 1'b1;
    advance();
    cnt_clr_i = 1'b0;
    n_chk++; if (grant_cnt_o[0] !== '0) begin n_fail++; $display("FAIL clr_priority: got %h required 0", grant_cnt_o[0]); end
    in_req_i = '0; en_i = '1;
    advance();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; cnt_clr_i = 1'b0; en_i = '1; in_req_i = '0; out_gnt_i = '0;
    out_r_valid_i = '0; out_r_rdata_i = '0; auto_resp = 1'b1;
    for (int h = 0; h < N_HWPE; h++)
      for (int p = 0; p < MP; p++) begin
        in_add_i[h][p] = 32'h1000 * (h + 1) + 32'(4 * p);
        in_wen_i[h][p] = 1'(p % 2);
        in_be_i[h][p] = '1;
        in_wdata_i[h][p] = $urandom;
      end
    test_reset();
    test_fairness();
    test_response();
    test_stall();
    test_masking();
    test_back_to_back();
    test_err_sat();
    #20;
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d outstanding required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hwpe_tcdm_port_arbiter.md
Name: hwpe_tcdm_port_arbiter

Overview:
- Shares one set of MP TCDM master ports between N_HWPE accelerator wrappers. Each wrapper drives MP TCDM ports; the cluster exposes a single set toward the logarithmic interconnect.
- Each port index p has its own round-robin arbiter. The arbiter records which requester won, so the one-cycle-later read response returns to that requester.
- Sits between the HWPE top wrappers and the hwacc_xbar_master port array. It also provides per-requester enable masking, saturating grant counters and a sticky protocol-error flag.

Parameters:
- N_HWPE, 2, number of requesting accelerators (>=1).
- MP, 4, TCDM ports per accelerator and number of shared output ports.
- AW, 32, address width.
- DW, 32, data width.
- BW, 4, byte-enable width (DW/8).
- CNT_W, 16, width of each saturating grant counter.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- en_i, in, N_HWPE, requester enable mask; a 0 makes that requester ineligible.
- cnt_clr_i, in, 1, synchronous clear of the grant counters and err_o.
- in_req_i, in, N_HWPE x MP, requester request.
- in_add_i, in, N_HWPE x MP x AW, address.
- in_wen_i, in, N_HWPE x MP, 1 = read, 0 = write (TCDM convention).
- in_be_i, in, N_HWPE x MP x BW, byte enable.
- in_wdata_i, in, N_HWPE x MP x DW, write data.
- in_gnt_o, out, N_HWPE x MP, grant to requester.
- in_r_rdata_o, out, N_HWPE x MP x DW, routed read data.
- in_r_valid_o, out, N_HWPE x MP, routed response valid.
- out_req_o, out, MP, shared port request.
- out_add_o, out, MP x AW, shared port address.
- out_wen_o, out, MP, shared port read/write select.
- out_be_o, out, MP x BW, shared port byte enable.
- out_wdata_o, out, MP x DW, shared port write data.
- out_gnt_i, in, MP, interconnect grant.
- out_r_rdata_i, in, MP x DW, interconnect read data.
- out_r_valid_i, in, MP x DW-independent 1 bit per port (MP), interconnect response valid.
- grant_cnt_o, out, N_HWPE x CNT_W, total handshakes per requester across all ports.
- busy_o, out, 1, OR of all eligible in_req_i and all pending-response bits.
- err_o, out, 1, sticky protocol error.

Behaviour:
- Reset: all registers update only on a clk_i edge with rst_i=1. After reset:
  - rr_ptr[p]=0, pend_vld[p]=0, pend_idx[p]=0, counters=0, err_o=0.
  - While rst_i=1, out_req_o, in_gnt_o and in_r_valid_o are forced to 0.
- Eligibility: requester h on port p is eligible when in_req_i[h][p] & en_i[h].
- Selection (combinational): the winner is the first eligible index starting at rr_ptr[p], with modulo-N_HWPE wrap.
  - out_req_o[p] = any eligible.
  - The winner's add/wen/be/wdata are muxed to out_*[p]. With no winner, the payload is all zeros.
- Grant: in_gnt_o[win][p] = out_gnt_i[p] & out_req_o[p]. All other requesters get gnt=0. Grant is combinational, zero added latency.
- Handshake: out_req_o[p] & out_gnt_i[p]. On a handshake:
  - rr_ptr[p] <= (win+1) mod N_HWPE; this wraps from N_HWPE-1 to 0.
  - pend_vld[p] <= 1 and pend_idx[p] <= win.
  - Without a handshake, pend_vld[p] <= 0 and rr_ptr[p] holds.
- Response: the interconnect asserts r_valid exactly one cycle after the grant, for reads and writes.
  - in_r_valid_o[pend_idx[p]][p] = out_r_valid_i[p] & pend_vld[p].
  - in_r_rdata_o for every requester on port p = out_r_rdata_i[p] (data broadcast, valid steered).
- Back-to-back: a new handshake in the same cycle as a response is legal. pend_* is overwritten with the new winner and the current response uses the old pend_idx.
- Errors: err_o is set when out_r_valid_i[p]=1 while pend_vld[p]=0. That response is dropped and err_o stays set until rst_i or cnt_clr_i.
- Counters:
  - grant_cnt_o[h] adds the popcount of handshakes won by h across all MP ports in that cycle.
  - Counters saturate at 2^CNT_W-1.
  - cnt_clr_i has priority over increment.
- Enable masking: en_i dropping mid-request removes eligibility in the same cycle. An already-pending response is still delivered.
- Single-requester case: N_HWPE=1 degenerates to pass-through plus one-cycle response tracking.
- Reset mid-transfer: pending responses are discarded. A late r_valid arriving after reset sets err_o.

Decomposition:
- hwpe_arb_pkg holds:
  - idx_t, a logic vector of width $clog2(N_HWPE) (minimum 1).
  - tcdm_req_t, a struct of add/wen/be/wdata.
  - The constant CNT_MAX.
- Sub-module hwpe_rr_arb_port: one instance per port p, generated MP times. It contains rr_ptr, the winner select, the payload mux, grant steering and the pend_vld/pend_idx register.
- The top level holds the counters, err_o and busy_o.

Test Plan:
1. Reset and idle: rst_i=1 for 2 cycles with all in_req=1 -> out_req_o=0 and in_gnt_o=0. After release, the first winner on every port is h=0.
2. Round-robin fairness: N_HWPE=2, both requesting port 0 continuously, out_gnt_i=1 -> grants alternate 0,1,0,1. After 8 cycles grant_cnt_o = {4,4}.
3. Response routing: h1 reads address 0x100 on port 2 and is granted at cycle t; r_valid at t+1 with data 0xDEADBEEF -> only in_r_valid_o[1][2]=1 and in_r_rdata_o[1][2]=0xDEADBEEF.
4. Stall: out_gnt_i=0 for 3 cycles with h0 and h1 requesting -> no in_gnt and rr_ptr unchanged. The first grant goes to rr_ptr's index.
5. Masking: en_i=2'b01 with both requesting -> only h0 granted and grant_cnt_o[1] stays 0.
6. Error and saturation: spurious out_r_valid_i[3] with no pending response -> err_o=1 on the next cycle and stays 1. With CNT_W=4 and 20 grants -> counter reads 15. cnt_clr_i -> counters 0 and err_o=0.
